// File: rtl/npu_ctrl_pkg.sv
// Shared types for the TinyNPU layer sequencer: FSM state encoding and trace width.
package npu_ctrl_pkg;

    localparam int TRACE_W = 4;

    typedef enum logic [2:0] {
        ST_LD0   = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_LD1   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [TRACE_W-1:0] trace_of(input state_t s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/npu_layer_ctrl_if.sv
// Controller <-> datapath/host signal bundle. master = controller side, slave = datapath/host side.
interface npu_layer_ctrl_if
    import npu_ctrl_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int MAX_LAYERS = 8
);
    localparam int LW = $clog2(MAX_LAYERS + 1);
    localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [LW-1:0]      cfg_layers;
    logic               d2c_x_load_val;
    logic               d2c_w_load_val;
    logic [SW-1:0]      d2c_w_load_sel;
    logic               d2c_mac_val;
    logic               d2c_x_fifo_empty;
    logic               d2c_x_fifo_full;
    logic [SIZE-1:0]    d2c_w_fifo_empty;
    logic               d2c_ostream_val;
    logic               out_rdy;

    logic               c2d_x_sel;
    logic               c2d_x_fifo_wen;
    logic [SIZE-1:0]    c2d_w_fifo_wen;
    logic               c2d_istream_val;
    logic               c2d_x_fifo_ren;
    logic               c2d_w_fifo_ren;
    logic               c2d_ostream_req;
    logic               c2d_ostream_ack;
    logic               out_val;
    logic               done;
    logic               err;
    logic [TRACE_W-1:0] trace_state;

    modport master (
        input  cfg_layers, d2c_x_load_val, d2c_w_load_val, d2c_w_load_sel, d2c_mac_val,
               d2c_x_fifo_empty, d2c_x_fifo_full, d2c_w_fifo_empty, d2c_ostream_val, out_rdy,
        output c2d_x_sel, c2d_x_fifo_wen, c2d_w_fifo_wen, c2d_istream_val, c2d_x_fifo_ren,
               c2d_w_fifo_ren, c2d_ostream_req, c2d_ostream_ack, out_val, done, err, trace_state
    );

    modport slave (
        output cfg_layers, d2c_x_load_val, d2c_w_load_val, d2c_w_load_sel, d2c_mac_val,
               d2c_x_fifo_empty, d2c_x_fifo_full, d2c_w_fifo_empty, d2c_ostream_val, out_rdy,
        input  c2d_x_sel, c2d_x_fifo_wen, c2d_w_fifo_wen, c2d_istream_val, c2d_x_fifo_ren,
               c2d_w_fifo_ren, c2d_ostream_req, c2d_ostream_ack, out_val, done, err, trace_state
    );

endinterface

// File: rtl/npu_counter.sv
// Wrapping up-counter 0..TERM with enable and synchronous clear; term flags the terminal value.
module npu_counter #(
    parameter int W    = 2,
    parameter int TERM = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic term
);
    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] cnt;

    assign term = (cnt == TERM_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/npu_layer_ctrl.sv
// Multi-layer sequencer for the systolic MAC array: load, stream, drain, output/feedback, repeat.
// state | meaning: LD0 host load | MAC stream | DRAIN pipeline wait | OUT output beats | LD1 weight reload | DONE pulse
module npu_layer_ctrl
    import npu_ctrl_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int MAC_LAT    = 3,
    parameter int MAX_LAYERS = 8
) (
    input  logic             clk,
    input  logic             rst,
    npu_layer_ctrl_if.master bus
);
    localparam int LW = $clog2(MAX_LAYERS + 1);
    localparam int SW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_t        state, state_nxt;
    logic [LW-1:0] layers_tgt, layer_idx;
    logic          err_q;
    logic          all_ne, all_e, last, fire, drain_term, beat_term;
    logic [SIZE-1:0] w_dec;

    assign all_ne = ~bus.d2c_x_fifo_empty & ~|bus.d2c_w_fifo_empty;
    assign all_e  = bus.d2c_x_fifo_empty & (&bus.d2c_w_fifo_empty);
    assign last   = (layer_idx == layers_tgt - LW'(1));
    // Final layer waits on the sink; earlier layers wait on room in the x FIFO.
    assign fire   = (state == ST_OUT) & bus.d2c_ostream_val &
                    (last ? bus.out_rdy : ~bus.d2c_x_fifo_full);

    npu_counter #(.W(DW), .TERM(MAC_LAT - 1)) u_drain_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_DRAIN),
        .clr  (state != ST_DRAIN),
        .term (drain_term)
    );

    npu_counter #(.W(BW), .TERM(SIZE - 1)) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (fire),
        .clr  (state != ST_OUT),
        .term (beat_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LD0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LD0, ST_LD1: if (bus.d2c_mac_val) state_nxt = ST_MAC;
            ST_MAC:         if (all_e) state_nxt = ST_DRAIN;
            ST_DRAIN:       if (drain_term) state_nxt = ST_OUT;
            ST_OUT:         if (fire && beat_term) state_nxt = last ? ST_DONE : ST_LD1;
            ST_DONE:        state_nxt = ST_LD0;
            default:        state_nxt = ST_LD0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layers_tgt <= LW'(1);
            layer_idx  <= '0;
        end else if (state == ST_LD0 && bus.d2c_mac_val) begin
            layers_tgt <= (bus.cfg_layers == '0) ? LW'(1) : bus.cfg_layers;
            layer_idx  <= '0;
        end else if (fire && beat_term && !last) begin
            layer_idx  <= layer_idx + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == ST_MAC && !all_ne && !all_e) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_dec[i] = bus.d2c_w_load_val && (bus.d2c_w_load_sel == SW'(i));
        end
    end

    always_comb begin
        bus.c2d_x_sel       = 1'b0;
        bus.c2d_x_fifo_wen  = 1'b0;
        bus.c2d_w_fifo_wen  = '0;
        bus.c2d_istream_val = 1'b0;
        bus.c2d_x_fifo_ren  = 1'b0;
        bus.c2d_w_fifo_ren  = 1'b0;
        bus.c2d_ostream_req = 1'b0;
        bus.c2d_ostream_ack = 1'b0;
        bus.out_val         = 1'b0;
        bus.done            = 1'b0;
        bus.err             = err_q;
        bus.trace_state     = trace_of(state);
        unique case (state)
            ST_LD0: begin
                bus.c2d_x_fifo_wen = bus.d2c_x_load_val;
                bus.c2d_w_fifo_wen = w_dec;
            end
            ST_LD1: begin
                bus.c2d_x_sel      = 1'b1;
                bus.c2d_w_fifo_wen = w_dec;
            end
            ST_MAC: begin
                bus.c2d_istream_val = all_ne;
                bus.c2d_x_fifo_ren  = all_ne;
                bus.c2d_w_fifo_ren  = all_ne;
            end
            ST_OUT: begin
                bus.c2d_ostream_req = 1'b1;
                bus.c2d_ostream_ack = fire;
                bus.out_val         = bus.d2c_ostream_val & last;
                if (!last) begin
                    bus.c2d_x_sel      = 1'b1;
                    bus.c2d_x_fifo_wen = fire;
                end
            end
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_npu_layer_ctrl.sv
// Bench for npu_layer_ctrl: LD0 decode table, FIFO-model driven runs with transaction-level expectations, corner sequences.
module tb_npu_layer_ctrl;
    import npu_ctrl_pkg::*;

    localparam int SIZE       = 4;
    localparam int MAC_LAT    = 3;
    localparam int MAX_LAYERS = 8;
    localparam int LW         = $clog2(MAX_LAYERS + 1);
    localparam int SW         = $clog2(SIZE);
    localparam int XDEPTH     = 8;
    localparam int RUN_BUDGET = 6000;

    logic clk = 1'b0;
    logic rst;

    npu_layer_ctrl_if #(.SIZE(SIZE), .MAX_LAYERS(MAX_LAYERS)) bus ();

    npu_layer_ctrl #(.SIZE(SIZE), .MAC_LAT(MAC_LAT), .MAX_LAYERS(MAX_LAYERS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int x_cnt;
    int w_cnt[SIZE];

    typedef struct {
        logic          xl;
        logic          wl;
        logic [SW-1:0] sel;
        int            exp_xwen;
        int            exp_wwen;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_now();
        return int'({bus.c2d_x_sel, bus.c2d_x_fifo_wen, bus.c2d_w_fifo_wen, bus.c2d_istream_val,
                     bus.c2d_x_fifo_ren, bus.c2d_w_fifo_ren, bus.c2d_ostream_req,
                     bus.c2d_ostream_ack, bus.out_val, bus.done, bus.err, bus.trace_state});
    endfunction

    task automatic idle();
        bus.cfg_layers      = '0;
        bus.d2c_x_load_val  = 1'b0;
        bus.d2c_w_load_val  = 1'b0;
        bus.d2c_w_load_sel  = '0;
        bus.d2c_mac_val     = 1'b0;
        bus.d2c_ostream_val = 1'b0;
        bus.out_rdy         = 1'b0;
    endtask

    task automatic apply_flags(input bit ff);
        bus.d2c_x_fifo_empty = (x_cnt == 0);
        bus.d2c_x_fifo_full  = ff || (x_cnt >= XDEPTH);
        for (int i = 0; i < SIZE; i++) bus.d2c_w_fifo_empty[i] = (w_cnt[i] == 0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        idle();
        x_cnt = 0;
        for (int i = 0; i < SIZE; i++) w_cnt[i] = 0;
        apply_flags(1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete run with a FIFO occupancy model standing in for the datapath.
    // mode 0 ideal, 1 sink backpressure 1,0,0,1, 2 random, 3 host noise during DRAIN.
    task automatic run(input int cfg, input int mode);
        int L, ld_k, cyc, st, prev_st, sel_i, exp_w, is_last, val, rdy, full, exp_fire;
        int n_ist, n_mac, n_drain, n_ack, n_outval, n_fb, n_ld1, n_ld1_xwen, n_ld1_wwen, n_done;
        int viol, lat_bad, gap_bad, drain_wen, out_cycles, last_pop, last_final_ack, bp_idx;
        bit finished, ff, all_w;
        string tag;
        L = (cfg == 0) ? 1 : cfg;
        ld_k = 0; cyc = 0; prev_st = -1;
        n_ist = 0; n_mac = 0; n_drain = 0; n_ack = 0; n_outval = 0; n_fb = 0; n_ld1 = 0;
        n_ld1_xwen = 0; n_ld1_wwen = 0; n_done = 0; viol = 0; lat_bad = 0; gap_bad = 0;
        drain_wen = 0; out_cycles = 0; last_pop = -100; last_final_ack = -100; bp_idx = 0;
        finished = 1'b0;
        tag = $sformatf("run_cfg%0d_mode%0d", cfg, mode);
        while (!finished && cyc < RUN_BUDGET) begin
            @(negedge clk);
            st = int'(bus.trace_state);
            idle();
            bus.cfg_layers = LW'(cfg);
            ff = 1'b0;
            sel_i = 0;
            if (st == 1) ld_k = 0;
            case (st)
                0, 4: begin
                    if (ld_k < SIZE * SIZE) begin
                        sel_i = ld_k % SIZE;
                        bus.d2c_w_load_val = 1'b1;
                        bus.d2c_w_load_sel = SW'(sel_i);
                        bus.d2c_x_load_val = (st == 4) || (ld_k < SIZE);
                        ld_k++;
                        if (mode == 2 && ld_k == SIZE * SIZE && $urandom_range(1) == 1)
                            bus.d2c_mac_val = 1'b1;
                    end else begin
                        bus.d2c_mac_val = 1'b1;
                    end
                end
                2: if (mode == 3) begin
                    bus.d2c_x_load_val = 1'b1;
                    bus.d2c_w_load_val = 1'b1;
                    bus.d2c_w_load_sel = SW'(cyc % SIZE);
                    bus.d2c_mac_val    = 1'b1;
                end
                3: begin
                    bus.d2c_ostream_val = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
                    if (mode == 1)      bus.out_rdy = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
                    else if (mode == 2) bus.out_rdy = ($urandom_range(1) == 1);
                    else                bus.out_rdy = 1'b1;
                    ff = (mode == 2) && ($urandom_range(3) == 0);
                    bp_idx++;
                end
                default: ;
            endcase
            apply_flags(ff);
            #1;
            if (st == 4 && prev_st != 4) n_ld1++;
            is_last = (n_ld1 == L - 1) ? 1 : 0;
            val  = int'(bus.d2c_ostream_val);
            rdy  = int'(bus.out_rdy);
            full = int'(bus.d2c_x_fifo_full);
            if (bus.err !== 1'b0) viol++;
            if (st == 3) begin
                exp_fire = (val == 1 && (is_last == 1 ? rdy == 1 : full == 0)) ? 1 : 0;
                if (prev_st != 3 && cyc - last_pop != MAC_LAT + 2) lat_bad++;
                out_cycles++;
                if (int'(bus.c2d_ostream_ack) != exp_fire) viol++;
                if (int'(bus.out_val) != (val & is_last)) viol++;
                if (int'(bus.c2d_x_sel) != 1 - is_last) viol++;
                if (int'(bus.c2d_x_fifo_wen) != (is_last == 1 ? 0 : exp_fire)) viol++;
                if (bus.c2d_ostream_req !== 1'b1) viol++;
                if (bus.c2d_ostream_ack) n_ack++;
                if (bus.c2d_ostream_ack && bus.out_val) begin
                    n_outval++;
                    last_final_ack = cyc;
                end
                if (bus.c2d_x_fifo_wen && bus.c2d_x_sel) n_fb++;
            end else if (bus.c2d_ostream_req || bus.c2d_ostream_ack || bus.out_val) begin
                viol++;
            end
            if (st == 1) begin
                n_mac++;
                all_w = 1'b1;
                for (int i = 0; i < SIZE; i++) if (w_cnt[i] == 0) all_w = 1'b0;
                if (int'(bus.c2d_istream_val) != ((x_cnt > 0 && all_w) ? 1 : 0)) viol++;
                if (bus.c2d_x_fifo_ren != bus.c2d_istream_val) viol++;
                if (bus.c2d_w_fifo_ren != bus.c2d_istream_val) viol++;
                if (bus.c2d_istream_val) begin
                    n_ist++;
                    last_pop = cyc;
                end
                if (bus.c2d_x_fifo_ren && x_cnt > 0) x_cnt--;
                if (bus.c2d_w_fifo_ren)
                    for (int i = 0; i < SIZE; i++) if (w_cnt[i] > 0) w_cnt[i]--;
            end else if (bus.c2d_istream_val || bus.c2d_x_fifo_ren || bus.c2d_w_fifo_ren) begin
                viol++;
            end
            if (st == 2) begin
                n_drain++;
                if (bus.c2d_x_fifo_wen || bus.c2d_w_fifo_wen != '0) drain_wen++;
            end
            if (st == 0 || st == 4) begin
                exp_w = bus.d2c_w_load_val ? (1 << sel_i) : 0;
                if (int'(bus.c2d_x_fifo_wen) != ((st == 0 && bus.d2c_x_load_val) ? 1 : 0)) viol++;
                if (int'(bus.c2d_x_sel) != ((st == 4) ? 1 : 0)) viol++;
                if (int'(bus.c2d_w_fifo_wen) != exp_w) viol++;
                if (st == 4) begin
                    n_ld1_xwen += int'(bus.c2d_x_fifo_wen);
                    n_ld1_wwen += (bus.c2d_w_fifo_wen != '0) ? 1 : 0;
                end
            end
            if (bus.c2d_x_fifo_wen) x_cnt++;
            for (int i = 0; i < SIZE; i++) if (bus.c2d_w_fifo_wen[i]) w_cnt[i]++;
            if (st == 5) begin
                n_done++;
                if (bus.done !== 1'b1) viol++;
                if (cyc - last_final_ack != 1) gap_bad++;
                finished = 1'b1;
            end else if (bus.done !== 1'b0) begin
                viol++;
            end
            prev_st = st;
            cyc++;
        end
        @(negedge clk);
        idle();
        apply_flags(1'b0);
        #1;
        check({tag, "_completed"}, int'(finished), 1);
        check({tag, "_back_to_ld0"}, int'(bus.trace_state), 0);
        check({tag, "_done_after_run"}, int'(bus.done), 0);
        check({tag, "_istream_beats"}, n_ist, SIZE * L);
        check({tag, "_mac_cycles"}, n_mac, (SIZE + 1) * L);
        check({tag, "_drain_cycles"}, n_drain, MAC_LAT * L);
        check({tag, "_acks"}, n_ack, SIZE * L);
        check({tag, "_final_beats"}, n_outval, SIZE);
        check({tag, "_feedback_writes"}, n_fb, SIZE * (L - 1));
        check({tag, "_ld1_entries"}, n_ld1, L - 1);
        check({tag, "_ld1_x_writes"}, n_ld1_xwen, 0);
        check({tag, "_ld1_w_writes"}, n_ld1_wwen, SIZE * SIZE * (L - 1));
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_cycle_rule_violations"}, viol, 0);
        check({tag, "_pop_to_out_latency"}, lat_bad, 0);
        check({tag, "_done_after_last_beat"}, gap_bad, 0);
        check({tag, "_drain_writes"}, drain_wen, 0);
        if (mode == 0) check({tag, "_out_cycles"}, out_cycles, SIZE * L);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1;
        idle();
        x_cnt = 0;
        for (int i = 0; i < SIZE; i++) w_cnt[i] = 0;
        apply_flags(1'b0);

        vecs[0] = '{1'b0, 1'b0, SW'(0), 0, 4'b0000};
        vecs[1] = '{1'b1, 1'b0, SW'(0), 1, 4'b0000};
        vecs[2] = '{1'b0, 1'b1, SW'(0), 0, 4'b0001};
        vecs[3] = '{1'b0, 1'b1, SW'(1), 0, 4'b0010};
        vecs[4] = '{1'b0, 1'b1, SW'(2), 0, 4'b0100};
        vecs[5] = '{1'b0, 1'b1, SW'(3), 0, 4'b1000};
        vecs[6] = '{1'b1, 1'b1, SW'(2), 1, 4'b0100};
        vecs[7] = '{1'b1, 1'b0, SW'(3), 1, 4'b0000};

        repeat (2) @(negedge clk);
        #1;
        check("reset_held_outputs", outs_now(), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_released_outputs", outs_now(), 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.d2c_x_load_val = vecs[i].xl;
            bus.d2c_w_load_val = vecs[i].wl;
            bus.d2c_w_load_sel = vecs[i].sel;
            #1;
            check($sformatf("ld0_vec%0d_x_wen", i), int'(bus.c2d_x_fifo_wen), vecs[i].exp_xwen);
            check($sformatf("ld0_vec%0d_w_wen", i), int'(bus.c2d_w_fifo_wen), vecs[i].exp_wwen);
            check($sformatf("ld0_vec%0d_sel_state", i), int'({bus.c2d_x_sel, bus.trace_state}), 0);
        end
        @(negedge clk);
        idle();

        run(1, 0);
        run(2, 0);
        run(1, 1);
        run(2, 1);
        run(0, 3);
        run(3, 3);
        run(MAX_LAYERS, 0);
        for (int r = 0; r < 8; r++) run(int'($urandom_range(MAX_LAYERS, 0)), 2);

        // Row 2 weights missing: stall with sticky error.
        rst_pulse();
        @(negedge clk);
        bus.d2c_mac_val      = 1'b1;
        bus.d2c_x_fifo_empty = 1'b0;
        bus.d2c_w_fifo_empty = 4'b0100;
        @(negedge clk);
        bus.d2c_mac_val = 1'b0;
        #1;
        check("mismatch_in_mac", int'(bus.trace_state), 1);
        check("mismatch_no_istream", int'(bus.c2d_istream_val), 0);
        check("mismatch_no_pops", int'({bus.c2d_x_fifo_ren, bus.c2d_w_fifo_ren}), 0);
        @(negedge clk);
        #1;
        check("mismatch_err_set", int'(bus.err), 1);
        check("mismatch_stalled", int'(bus.trace_state), 1);
        @(negedge clk);
        bus.d2c_x_fifo_empty = 1'b1;
        bus.d2c_w_fifo_empty = 4'b1111;
        repeat (MAC_LAT + 1) @(negedge clk);
        #1;
        check("mismatch_reaches_out", int'(bus.trace_state), 3);
        check("mismatch_err_sticky", int'(bus.err), 1);
        rst_pulse();
        #1;
        check("mismatch_err_cleared_by_rst", int'(bus.err), 0);

        // Asynchronous reset while in OUT.
        @(negedge clk);
        bus.d2c_mac_val = 1'b1;
        @(negedge clk);
        bus.d2c_mac_val = 1'b0;
        guard = 0;
        while (bus.trace_state != 4'd3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("arst_reached_out", int'(bus.trace_state), 3);
        bus.d2c_ostream_val = 1'b1;
        bus.out_rdy         = 1'b0;
        #1;
        check("arst_out_active", int'({bus.c2d_ostream_req, bus.out_val}), 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_immediate_outputs", outs_now(), 0);
        @(posedge clk);
        #1;
        check("arst_no_done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("arst_after_release", int'({bus.done, bus.trace_state}), 0);
        @(negedge clk);
        #1;
        check("arst_stays_ld0", int'({bus.done, bus.trace_state}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
